// File: rtl/mult_wb_scheduler_if.sv
// Decode-side and write-back-side signal bundle of the multiply/ALU issue scheduler.
// The decode stage is the master; the scheduler is the slave.
interface mult_wb_scheduler_if #(
    parameter int REG_ADDR = 5,
    parameter int NREGS    = 32
);
    logic                id_valid;
    logic                id_is_mult;
    logic                id_regwrite;
    logic [REG_ADDR-1:0] id_dst_reg;
    logic [REG_ADDR-1:0] id_src1;
    logic [REG_ADDR-1:0] id_src2;
    logic                flush;
    logic                stall;
    logic                issue;
    logic                m1_valid;
    logic                wb_valid;
    logic                wb_from_mult;
    logic [REG_ADDR-1:0] wb_dst;
    logic [NREGS-1:0]    busy;
    logic [2:0]          mult_inflight;

    modport master (
        output id_valid, id_is_mult, id_regwrite, id_dst_reg, id_src1, id_src2, flush,
        input  stall, issue, m1_valid, wb_valid, wb_from_mult, wb_dst, busy, mult_inflight
    );

    modport slave (
        input  id_valid, id_is_mult, id_regwrite, id_dst_reg, id_src1, id_src2, flush,
        output stall, issue, m1_valid, wb_valid, wb_from_mult, wb_dst, busy, mult_inflight
    );
endinterface

// File: rtl/mult_wb_scheduler.sv
// Issue scheduler sharing one register-file write port between the ALU pipe and
// the multiplier pipe, using a write-port reservation shift register and a mult scoreboard.
module mult_wb_scheduler #(
    parameter int REG_ADDR = 5,
    parameter int NREGS    = 32,
    parameter int MULT_LAT = 5,
    parameter int ALU_LAT  = 3
) (
    input logic               clk,
    input logic               reset,
    mult_wb_scheduler_if.slave sif
);
    logic [MULT_LAT-1:0] res_v;
    logic [MULT_LAT-1:0] res_mult;
    logic [REG_ADDR-1:0] res_dst [MULT_LAT];
    logic [MULT_LAT-1:0] nxt_v;
    logic [MULT_LAT-1:0] nxt_mult;
    logic [REG_ADDR-1:0] nxt_dst [MULT_LAT];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_nxt;
    logic [2:0]          inflight_q;
    logic [2:0]          inflight_nxt;

    logic wb_mult_valid;
    logic byp1, byp2, bypd;
    logic raw1, raw2, waw, structural;
    logic stall_c, issue_c, reserve, inc, dec;

    // A mult being written this cycle is readable (write-before-read register file).
    assign wb_mult_valid = res_v[0] & res_mult[0];
    assign byp1 = wb_mult_valid && (res_dst[0] == sif.id_src1);
    assign byp2 = wb_mult_valid && (res_dst[0] == sif.id_src2);
    assign bypd = wb_mult_valid && (res_dst[0] == sif.id_dst_reg);

    assign raw1 = (sif.id_src1 != '0) && busy_q[sif.id_src1] && !byp1;
    assign raw2 = (sif.id_src2 != '0) && busy_q[sif.id_src2] && !byp2;
    assign waw  = sif.id_regwrite && (sif.id_dst_reg != '0) && busy_q[sif.id_dst_reg] && !bypd;
    // An ALU reservation lands in res[ALU_LAT-1], which res[ALU_LAT] is about to shift into.
    assign structural = !sif.id_is_mult && sif.id_regwrite && res_v[ALU_LAT];

    assign stall_c = sif.id_valid & (raw1 | raw2 | waw | structural);
    assign issue_c = sif.id_valid & ~stall_c & ~sif.flush;
    assign reserve = issue_c & sif.id_regwrite;
    assign inc     = reserve & sif.id_is_mult;

    assign sif.stall         = stall_c;
    assign sif.issue         = issue_c;
    assign sif.m1_valid      = issue_c & sif.id_is_mult;
    assign sif.wb_valid      = res_v[0];
    assign sif.wb_from_mult  = res_mult[0];
    assign sif.wb_dst        = res_dst[0];
    assign sif.busy          = busy_q;
    assign sif.mult_inflight = inflight_q;

    always_comb begin
        nxt_v    = '0;
        nxt_mult = '0;
        for (int k = 0; k < MULT_LAT; k++) nxt_dst[k] = '0;
        for (int k = 0; k < MULT_LAT - 1; k++) begin
            nxt_v[k]    = res_v[k+1];
            nxt_mult[k] = res_mult[k+1];
            nxt_dst[k]  = res_dst[k+1];
        end
        if (reserve) begin
            if (sif.id_is_mult) begin
                nxt_v[MULT_LAT-1]    = 1'b1;
                nxt_mult[MULT_LAT-1] = 1'b1;
                nxt_dst[MULT_LAT-1]  = sif.id_dst_reg;
            end else begin
                nxt_v[ALU_LAT-1]    = 1'b1;
                nxt_mult[ALU_LAT-1] = 1'b0;
                nxt_dst[ALU_LAT-1]  = sif.id_dst_reg;
            end
        end
    end

    // Busy clears as the entry reaches res[0], so it reads 0 in its write-back cycle.
    assign dec = nxt_v[0] & nxt_mult[0];

    always_comb begin
        busy_nxt = busy_q;
        if (dec) busy_nxt[nxt_dst[0]] = 1'b0;
        if (inc && (sif.id_dst_reg != '0)) busy_nxt[sif.id_dst_reg] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        case ({inc, dec})
            2'b10:   inflight_nxt = inflight_q + 3'd1;
            2'b01:   inflight_nxt = inflight_q - 3'd1;
            default: inflight_nxt = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_v      <= '0;
            res_mult   <= '0;
            for (int k = 0; k < MULT_LAT; k++) res_dst[k] <= '0;
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            res_v      <= nxt_v;
            res_mult   <= nxt_mult;
            for (int k = 0; k < MULT_LAT; k++) res_dst[k] <= nxt_dst[k];
            busy_q     <= busy_nxt;
            inflight_q <= inflight_nxt;
        end
    end
endmodule
